// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - KxK window / tap address sequencer for the convolution datapath
module conv_window_sequencer #(
    parameter int IMG_W   = 16,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int ADDR_W  = 10,
    parameter int FADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               addr_ready,
    input  logic               win_ack,
    output logic               busy,
    output logic               done,
    output logic               addr_valid,
    output logic               ram_en,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [FADDR_W-1:0] rom_addr,
    output logic               tap_last,
    output logic               win_last
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam logic [ADDR_W-1:0]  A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0]  TAP_WRAP = ADDR_W'(IMG_W - K + 1);
    localparam logic [ADDR_W-1:0]  LAST_POS = ADDR_W'(OUT_W - 1);
    localparam logic [FADDR_W-1:0] F_ONE    = FADDR_W'(1);
    localparam logic [FADDR_W-1:0] KX_LAST  = FADDR_W'(K - 1);
    localparam logic [FADDR_W-1:0] ROM_LAST = FADDR_W'(K * K - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FIN} state_t;

    state_t              state, n_state;
    logic [FADDR_W-1:0]  kx, n_kx;
    logic [ADDR_W-1:0]   col, n_col, row, n_row;
    logic [ADDR_W-1:0]   row_base, n_row_base, win_base, n_win_base, tap_off, n_tap_off;
    logic [ADDR_W-1:0]   n_ram_addr;
    logic [FADDR_W-1:0]  n_rom_addr;
    logic                n_tap_last, n_win_last, n_addr_valid, n_busy, n_done;

    assign ram_en = addr_valid & addr_ready;

    // Address = window base (row/col origin) + tap offset within the window; both stepped incrementally.
    always_comb begin
        n_state      = state;
        n_kx         = kx;
        n_col        = col;
        n_row        = row;
        n_row_base   = row_base;
        n_win_base   = win_base;
        n_tap_off    = tap_off;
        n_ram_addr   = ram_addr;
        n_rom_addr   = rom_addr;
        n_tap_last   = tap_last;
        n_win_last   = win_last;
        n_addr_valid = addr_valid;
        n_busy       = busy;
        n_done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    n_state      = ISSUE;
                    n_busy       = 1'b1;
                    n_addr_valid = 1'b1;
                    n_tap_last   = (ROM_LAST == '0);
                    n_win_last   = (LAST_POS == '0);
                end
            end
            ISSUE: begin
                if (addr_ready) begin
                    if (tap_last) begin
                        n_state      = WAIT_ACK;
                        n_addr_valid = 1'b0;
                    end else begin
                        if (kx == KX_LAST) begin
                            n_kx      = '0;
                            n_tap_off = tap_off + TAP_WRAP;
                        end else begin
                            n_kx      = kx + F_ONE;
                            n_tap_off = tap_off + A_ONE;
                        end
                        n_rom_addr = rom_addr + F_ONE;
                        n_ram_addr = win_base + n_tap_off;
                        n_tap_last = (n_rom_addr == ROM_LAST);
                    end
                end
            end
            WAIT_ACK: begin
                if (win_ack) begin
                    if (win_last) begin
                        n_state = FIN;
                        n_done  = 1'b1;
                    end else begin
                        if (col == LAST_POS) begin
                            n_col      = '0;
                            n_row      = row + A_ONE;
                            n_row_base = row_base + ROW_STEP;
                            n_win_base = row_base + ROW_STEP;
                        end else begin
                            n_col      = col + A_ONE;
                            n_win_base = win_base + COL_STEP;
                        end
                        n_kx         = '0;
                        n_tap_off    = '0;
                        n_rom_addr   = '0;
                        n_ram_addr   = n_win_base;
                        n_tap_last   = (ROM_LAST == '0);
                        n_win_last   = (n_col == LAST_POS) && (n_row == LAST_POS);
                        n_addr_valid = 1'b1;
                        n_state      = ISSUE;
                    end
                end
            end
            default: ;
        endcase
        // Abort wins over every other event; leaving FIN takes the same clean-slate path.
        if (abort || state == FIN) begin
            n_state      = IDLE;
            n_kx         = '0;
            n_col        = '0;
            n_row        = '0;
            n_row_base   = '0;
            n_win_base   = '0;
            n_tap_off    = '0;
            n_ram_addr   = '0;
            n_rom_addr   = '0;
            n_tap_last   = 1'b0;
            n_win_last   = 1'b0;
            n_addr_valid = 1'b0;
            n_busy       = 1'b0;
            n_done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            kx         <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            win_base   <= '0;
            tap_off    <= '0;
            ram_addr   <= '0;
            rom_addr   <= '0;
            tap_last   <= 1'b0;
            win_last   <= 1'b0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= n_state;
            kx         <= n_kx;
            col        <= n_col;
            row        <= n_row;
            row_base   <= n_row_base;
            win_base   <= n_win_base;
            tap_off    <= n_tap_off;
            ram_addr   <= n_ram_addr;
            rom_addr   <= n_rom_addr;
            tap_last   <= n_tap_last;
            win_last   <= n_win_last;
            addr_valid <= n_addr_valid;
            busy       <= n_busy;
            done       <= n_done;
        end
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed checks of conv_window_sequencer on three geometries
module tb_conv_window_sequencer;
    logic clk = 1'b0, reset = 1'b0, abort = 1'b0, addr_ready = 1'b1;

    logic start_a = 1'b0, auto_a = 1'b0, spur_a = 1'b0, win_ack_a;
    logic busy_a, done_a, addr_valid_a, ram_en_a, tap_last_a, win_last_a;
    logic [9:0] ram_addr_a;
    logic [3:0] rom_addr_a;
    logic start_b = 1'b0, auto_b = 1'b0;
    logic busy_b, done_b, addr_valid_b, ram_en_b, tap_last_b, win_last_b;
    logic [9:0] ram_addr_b;
    logic [3:0] rom_addr_b;
    logic start_c = 1'b0, auto_c = 1'b0;
    logic busy_c, done_c, addr_valid_c, ram_en_c, tap_last_c, win_last_c;
    logic [9:0] ram_addr_c;
    logic [3:0] rom_addr_c;

    assign win_ack_a = auto_a | spur_a;

    conv_window_sequencer #(.IMG_W(4), .K(3), .STRIDE(1), .ADDR_W(10), .FADDR_W(4)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort), .addr_ready(addr_ready),
        .win_ack(win_ack_a), .busy(busy_a), .done(done_a), .addr_valid(addr_valid_a),
        .ram_en(ram_en_a), .ram_addr(ram_addr_a), .rom_addr(rom_addr_a),
        .tap_last(tap_last_a), .win_last(win_last_a));
    conv_window_sequencer #(.IMG_W(5), .K(3), .STRIDE(2), .ADDR_W(10), .FADDR_W(4)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort), .addr_ready(addr_ready),
        .win_ack(auto_b), .busy(busy_b), .done(done_b), .addr_valid(addr_valid_b),
        .ram_en(ram_en_b), .ram_addr(ram_addr_b), .rom_addr(rom_addr_b),
        .tap_last(tap_last_b), .win_last(win_last_b));
    conv_window_sequencer #(.IMG_W(3), .K(3), .STRIDE(1), .ADDR_W(10), .FADDR_W(4)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort), .addr_ready(addr_ready),
        .win_ack(auto_c), .busy(busy_c), .done(done_c), .addr_valid(addr_valid_c),
        .ram_en(ram_en_c), .ram_addr(ram_addr_c), .rom_addr(rom_addr_c),
        .tap_last(tap_last_c), .win_last(win_last_c));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int exp_a[36], exp_b[36];
    int base_a[4] = '{0, 1, 4, 5};
    int off_a[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int base_b[4] = '{0, 2, 10, 12};
    int off_b[9]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int idx_a = 0, ren_a = 0, dcnt_a = 0, idx_b = 0, ren_b = 0, dcnt_b = 0;
    int idx_c = 0, ren_c = 0, dcnt_c = 0;
    int wc_a = 0, wc_b = 0, wc_c = 0, ph = 0, abort_at = -1;
    bit rdy_mode = 1'b0, aborted = 1'b0, dist_done = 1'b0, ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Inputs are driven shortly after the rising edge, from the registered outputs of that cycle.
    always @(posedge clk) begin
        #2;
        addr_ready = rdy_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
        if (rdy_mode) ph++;
        abort = (abort_at >= 0) && (idx_a == abort_at) && addr_valid_a;
        if (abort) aborted = 1'b1;
        wc_a = (busy_a && !addr_valid_a && !done_a) ? wc_a + 1 : 0;
        wc_b = (busy_b && !addr_valid_b && !done_b) ? wc_b + 1 : 0;
        wc_c = (busy_c && !addr_valid_c && !done_c) ? wc_c + 1 : 0;
        auto_a = (wc_a == 2);
        auto_b = (wc_b == 2);
        auto_c = (wc_c == 2);
    end

    always @(negedge clk) begin
        if (addr_valid_a && idx_a < 36) begin
            check("a_ram_addr", ram_addr_a, exp_a[idx_a]);
            check("a_rom_addr", rom_addr_a, idx_a % 9);
            check("a_tap_last", tap_last_a, (idx_a % 9) == 8);
            check("a_win_last", win_last_a, idx_a >= 27);
        end
        if (ram_en_a) begin ren_a++; if (!abort) idx_a++; end
        if (done_a) dcnt_a++;
        if (ram_en_b) begin
            if (idx_b < 36) begin
                check("b_ram_addr", ram_addr_b, exp_b[idx_b]);
                check("b_win_last", win_last_b, idx_b >= 27);
            end
            idx_b++; ren_b++;
        end
        if (done_b) dcnt_b++;
        if (ram_en_c) begin
            check("c_ram_addr", ram_addr_c, idx_c);
            check("c_rom_addr", rom_addr_c, idx_c);
            check("c_win_last", win_last_c, 1);
            check("c_tap_last", tap_last_c, idx_c == 8);
            idx_c++; ren_c++;
        end
        if (done_c) dcnt_c++;
    end

    task automatic run_a(input bit rmode, input int ab_at, input bit disturb);
        rdy_mode = rmode; ph = 0; abort_at = ab_at; aborted = 1'b0; dist_done = 1'b0;
        idx_a = 0; ren_a = 0; dcnt_a = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("a_first_valid", addr_valid_a, 1);
        check("a_busy_run", busy_a, 1);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (disturb && idx_a >= 3 && !dist_done) begin
                start_a = 1'b1; spur_a = 1'b1; dist_done = 1'b1;
            end else begin
                start_a = 1'b0; spur_a = 1'b0;
            end
            if (dcnt_a > 0 || aborted) begin ok = 1'b1; break; end
        end
        start_a = 1'b0; spur_a = 1'b0;
        check("a_timeout", ok, 1);
        if (ab_at < 0) begin
            repeat (3) @(negedge clk);
            check("a_done_count", dcnt_a, 1);
            check("a_busy_end", busy_a, 0);
            check("a_ram_en_count", ren_a, 36);
            check("a_tap_count", idx_a, 36);
        end else begin
            @(negedge clk);
            check("a_abort_busy", busy_a, 0);
            check("a_abort_valid", addr_valid_a, 0);
            repeat (3) @(negedge clk);
            check("a_abort_no_done", dcnt_a, 0);
            check("a_abort_tap", idx_a, ab_at);
        end
        rdy_mode = 1'b0; abort_at = -1;
    endtask

    task automatic run_b();
        idx_b = 0; ren_b = 0; dcnt_b = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dcnt_b > 0) begin ok = 1'b1; break; end
        end
        check("b_timeout", ok, 1);
        repeat (3) @(negedge clk);
        check("b_ram_en_count", ren_b, 36);
        check("b_done_count", dcnt_b, 1);
        check("b_busy_end", busy_b, 0);
    endtask

    task automatic run_c();
        idx_c = 0; ren_c = 0; dcnt_c = 0;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        check("c_win_last_first", win_last_c, 1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dcnt_c > 0) begin ok = 1'b1; break; end
        end
        check("c_timeout", ok, 1);
        repeat (3) @(negedge clk);
        check("c_ram_en_count", ren_c, 9);
        check("c_done_count", dcnt_c, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 36; i++) begin
            exp_a[i] = base_a[i / 9] + off_a[i % 9];
            exp_b[i] = base_b[i / 9] + off_b[i % 9];
        end
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", addr_valid_a, 0);
        check("rst_ram_addr", ram_addr_a, 0);
        check("rst_rom_addr", rom_addr_a, 0);
        check("rst_tap_last", tap_last_a, 0);
        check("rst_win_last", win_last_a, 0);
        check("rst_busy_b", busy_b, 0);
        reset = 1'b1;
        @(negedge clk);

        run_a(1'b0, -1, 1'b0);
        run_b();
        run_a(1'b1, -1, 1'b0);
        run_a(1'b0, 13, 1'b0);
        run_a(1'b0, -1, 1'b0);

        idx_a = 0; ren_a = 0; dcnt_a = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (idx_a >= 5) begin ok = 1'b1; break; end
        end
        check("rst_mid_reach", ok, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_valid", addr_valid_a, 0);
        check("rst_mid_ram_en", ram_en_a, 0);
        check("rst_mid_ram_addr", ram_addr_a, 0);
        check("rst_mid_rom_addr", rom_addr_a, 0);
        check("rst_mid_tap_last", tap_last_a, 0);
        check("rst_mid_win_last", win_last_a, 0);
        check("rst_mid_done", done_a, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        run_a(1'b0, -1, 1'b1);
        run_c();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
